// File: rtl/ddram_responder_if.sv
// Avalon-MM style DDR3 port bundle shared by the core's DDR initiator and ddram_responder.
interface ddram_responder_if;
  logic        rd;
  logic        we;
  logic [28:0] addr;
  logic [7:0]  burstcnt;
  logic [63:0] din;
  logic [7:0]  be;
  logic        busy;
  logic [63:0] dout;
  logic        dout_ready;
  logic        error;

  modport master (
    output rd, we, addr, burstcnt, din, be,
    input  busy, dout, dout_ready, error
  );

  modport slave (
    input  rd, we, addr, burstcnt, din, be,
    output busy, dout, dout_ready, error
  );
endinterface

// File: rtl/ddram_responder.sv
// Block-RAM backed burst responder for the DDR3 port (single/burst reads and writes, byte enables).
// Optional DDRAM_RESPONDER_STALL_EN: LFSR-driven pseudo-random wait-request in IDLE and WRITE.
module ddram_responder #(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 4,
  parameter int MAX_BURST    = 128
) (
  input  logic             clock,
  input  logic             reset_n,
  ddram_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, RD_STREAM} state_t;

  localparam int unsigned WORDS = 2 ** ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [7:0]            rem_q, rem_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  error_q, error_d;
  logic                  rst_busy_q;
  logic [63:0]           dout_q;
  logic                  dout_ready_q;
  logic                  busy;
  logic                  stall;
  logic [7:0]            req_len;
  logic                  req_clamp;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_en;
  logic [63:0]           mem [WORDS];

`ifdef DDRAM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clock) begin
    if (!reset_n) lfsr_q <= 16'hACE1;
    else          lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Read states are always busy, so stall may be OR-ed in unconditionally.
  assign busy = rst_busy_q | (state_q == RD_WAIT) | (state_q == RD_STREAM) | stall;

  always_comb begin
    req_clamp = 1'b0;
    if (bus.burstcnt == '0) begin
      req_len = 8'd1;
    end else if (int'(bus.burstcnt) > MAX_BURST) begin
      req_len   = 8'(MAX_BURST);
      req_clamp = 1'b1;
    end else begin
      req_len = bus.burstcnt;
    end
  end

  // The first RAM read is issued on the edge leaving RD_WAIT, so the registered
  // read output lands exactly READ_LATENCY edges after acceptance.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    wr_en   = 1'b0;
    wr_addr = ptr_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!busy) begin
          if (bus.we) begin
            wr_en   = 1'b1;
            wr_addr = bus.addr[ADDR_WIDTH-1:0];
            error_d = error_q | bus.rd | req_clamp;
            ptr_d   = bus.addr[ADDR_WIDTH-1:0] + 1'b1;
            rem_d   = req_len - 8'd1;
            if (req_len != 8'd1) state_d = WRITE;
          end else if (bus.rd) begin
            error_d = error_q | req_clamp;
            ptr_d   = bus.addr[ADDR_WIDTH-1:0];
            rem_d   = req_len - 8'd1;
            cnt_d   = 4'(READ_LATENCY - 1);
            state_d = RD_WAIT;
          end
        end
      end
      WRITE: begin
        if (bus.rd) error_d = 1'b1;
        if (bus.we && !busy) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rd_en   = 1'b1;
          ptr_d   = ptr_q + 1'b1;
          state_d = RD_STREAM;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_STREAM: begin
        if (rem_q == '0) begin
          state_d = IDLE;
        end else begin
          rd_en = 1'b1;
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      error_q      <= 1'b0;
      rst_busy_q   <= 1'b1;
      dout_q       <= '0;
      dout_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      error_q      <= error_d;
      rst_busy_q   <= 1'b0;
      dout_ready_q <= rd_en;
      if (rd_en) dout_q <= mem[ptr_q];
    end
  end

  // RAM contents survive reset; beats of an abandoned write burst are dropped.
  always_ff @(posedge clock) begin
    if (wr_en && reset_n) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (bus.be[i]) mem[wr_addr][8*i +: 8] <= bus.din[8*i +: 8];
      end
    end
  end

  assign bus.busy       = busy;
  assign bus.dout       = dout_q;
  assign bus.dout_ready = dout_ready_q;
  assign bus.error      = error_q;
endmodule

// File: tb/tb_ddram_responder.sv
// Self-checking bench for ddram_responder against a word-array reference model.
module tb_ddram_responder;
  localparam int LAT   = 4;
  localparam int WORDS = 4096;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  ddram_responder_if bus ();

  ddram_responder #(.ADDR_WIDTH(12), .READ_LATENCY(LAT), .MAX_BURST(128)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] ref_mem [WORDS];
  logic [63:0] wq [128];
  logic [7:0]  bq [128];
  logic [15:0] m_lfsr;

  // Reference wait-request source: 16-bit Fibonacci LFSR, taps 16,14,13,11.
  always @(posedge clock) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic exp_idle_busy();
`ifdef DDRAM_RESPONDER_STALL_EN
    return (m_lfsr % 4) == 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] mask_of(input logic [7:0] b);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{b[i]}};
    return m;
  endfunction

  task automatic model_write(input int w, input logic [63:0] d, input logic [7:0] b);
    int idx = w % WORDS;
    ref_mem[idx] = (ref_mem[idx] & ~mask_of(b)) | (d & mask_of(b));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Holds the current offer until an edge with busy=0, checking busy every cycle.
  task automatic offer(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      n_cmp++;
      if (bus.busy !== exp_idle_busy()) begin
        n_err++;
        $display("FAIL idle_busy got %0b exp %0b", bus.busy, exp_idle_busy());
      end
      if (bus.busy === 1'b0) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout got busy=%0b exp acceptance", bus.busy);
    end
  endtask

  task automatic write_burst(input int a, input int n, input int gap_after);
    bit ok;
    for (int i = 0; i < n; i++) begin
      bus.we       = 1'b1;
      bus.addr     = (i == 0) ? 29'(a) : 29'($urandom);
      bus.burstcnt = (i == 0) ? 8'(n) : 8'($urandom);
      bus.din      = wq[i];
      bus.be       = bq[i];
      offer(ok);
      bus.we = 1'b0;
      if (ok) model_write(a + i, wq[i], bq[i]);
      if (i + 1 == gap_after && i < n - 1) tick();
    end
  endtask

  task automatic read_burst(input int a, input logic [7:0] bc, input int n);
    bit ok;
    logic        exp_rdy, exp_busy;
    logic [63:0] exp_d;
    bus.rd       = 1'b1;
    bus.addr     = 29'(a);
    bus.burstcnt = bc;
    offer(ok);
    bus.rd       = 1'b0;
    bus.addr     = 29'($urandom);
    bus.burstcnt = 8'($urandom);
    if (!ok) return;
    exp_d = '0;
    for (int k = 0; k <= LAT + n; k++) begin
      if (k > 0) tick();
      exp_rdy  = (k >= LAT) && (k < LAT + n);
      exp_busy = (k < LAT + n) ? 1'b1 : exp_idle_busy();
      if (exp_rdy) exp_d = ref_mem[(a + k - LAT) % WORDS];
      n_cmp++;
      if (bus.dout_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL rd_ready a=%0d k=%0d got %0b exp %0b", a, k, bus.dout_ready, exp_rdy);
      end
      n_cmp++;
      if (bus.busy !== exp_busy) begin
        n_err++;
        $display("FAIL rd_busy a=%0d k=%0d got %0b exp %0b", a, k, bus.busy, exp_busy);
      end
      if (k >= LAT) begin
        n_cmp++;
        if (bus.dout !== exp_d) begin
          n_err++;
          $display("FAIL rd_data a=%0d k=%0d got %h exp %h", a, k, bus.dout, exp_d);
        end
      end
    end
  endtask

  task automatic check_error(input string tag, input logic exp);
    n_cmp++;
    if (bus.error !== exp) begin
      n_err++;
      $display("FAIL error_%s got %0b exp %0b", tag, bus.error, exp);
    end
  endtask

  task automatic apply_reset();
    bus.rd  = 1'b0;
    bus.we  = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.rd = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.burstcnt = '0; bus.din = '0; bus.be = '0;
    reset_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.dout_ready !== 1'b0 || bus.dout !== 64'd0) begin
      n_err++;
      $display("FAIL reset_outputs got busy=%0b rdy=%0b dout=%h exp 1 0 0", bus.busy, bus.dout_ready, bus.dout);
    end
    check_error("reset", 1'b0);
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.busy !== exp_idle_busy()) begin
      n_err++;
      $display("FAIL reset_release_busy got %0b exp %0b", bus.busy, exp_idle_busy());
    end
  endtask

  task automatic test_single();
    wq[0] = 64'h0123_4567_89AB_CDEF; bq[0] = 8'hFF;
    write_burst(5, 1, 0);
    read_burst(5, 8'd1, 1);
  endtask

  task automatic test_byte_enables();
    wq[0] = 64'hFFFF_FFFF_FFFF_FFFF; bq[0] = 8'hFF;
    write_burst(9, 1, 0);
    wq[0] = 64'h0; bq[0] = 8'h0F;
    write_burst(9, 1, 0);
    read_burst(9, 8'd1, 1);
  endtask

  task automatic test_burst_wrap();
    for (int i = 0; i < 4; i++) begin wq[i] = 64'(i + 1); bq[i] = 8'hFF; end
    write_burst(4094, 4, 2);
    read_burst(4094, 8'd4, 4);
  endtask

  task automatic test_zero_and_clamp();
    wq[0] = 64'hDEAD_BEEF_0000_0077; bq[0] = 8'hFF;
    write_burst(700, 1, 0);
    read_burst(700, 8'd0, 1);
    check_error("zero_len", 1'b0);
    for (int i = 0; i < 128; i++) begin wq[i] = {$urandom, $urandom}; bq[i] = 8'hFF; end
    write_burst(1000, 128, 0);
    check_error("max_len", 1'b0);
    read_burst(1000, 8'd200, 128);
    check_error("clamp", 1'b1);
    apply_reset();
    check_error("after_reset", 1'b0);
  endtask

  task automatic test_rd_we_conflict();
    bit ok;
    check_error("pre_conflict", 1'b0);
    bus.rd = 1'b1; bus.we = 1'b1; bus.addr = 29'd300; bus.burstcnt = 8'd1;
    bus.din = 64'h5555_AAAA_1234_8765; bus.be = 8'hFF;
    offer(ok);
    bus.rd = 1'b0; bus.we = 1'b0;
    if (ok) model_write(300, 64'h5555_AAAA_1234_8765, 8'hFF);
    for (int k = 0; k < LAT + 3; k++) begin
      n_cmp++;
      if (bus.dout_ready !== 1'b0) begin
        n_err++;
        $display("FAIL conflict_no_read k=%0d got %0b exp 0", k, bus.dout_ready);
      end
      tick();
    end
    check_error("conflict", 1'b1);
    read_burst(300, 8'd1, 1);
    check_error("sticky", 1'b1);
  endtask

  task automatic test_reset_mid_stream();
    bit ok;
    int beats;
    apply_reset();
    for (int i = 0; i < 8; i++) begin wq[i] = {$urandom, $urandom}; bq[i] = 8'hFF; end
    write_burst(100, 8, 0);
    bus.rd = 1'b1; bus.addr = 29'd100; bus.burstcnt = 8'd8;
    offer(ok);
    bus.rd = 1'b0;
    beats = 0;
    for (int k = 0; k < 40 && beats < 3; k++) begin
      tick();
      if (bus.dout_ready === 1'b1) begin
        n_cmp++;
        if (bus.dout !== ref_mem[100 + beats]) begin
          n_err++;
          $display("FAIL midrst_beat%0d got %h exp %h", beats, bus.dout, ref_mem[100 + beats]);
        end
        beats++;
      end
    end
    n_cmp++;
    if (beats != 3) begin
      n_err++;
      $display("FAIL midrst_beats got %0d exp 3", beats);
    end
    reset_n = 1'b0;
    tick();
    n_cmp++;
    if (bus.dout_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_abort got rdy=%0b busy=%0b exp 0 1", bus.dout_ready, bus.busy);
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.busy !== exp_idle_busy()) begin
      n_err++;
      $display("FAIL midrst_release_busy got %0b exp %0b", bus.busy, exp_idle_busy());
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (bus.dout_ready !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_stray_beat k=%0d got 1 exp 0", k);
      end
      tick();
    end
    read_burst(100, 8'd8, 8);
  endtask

  task automatic test_random();
    int a, n, gap;
    for (int it = 0; it < 12; it++) begin
      a   = $urandom_range(0, WORDS - 1);
      n   = $urandom_range(1, 8);
      gap = $urandom_range(0, n);
      for (int i = 0; i < n; i++) begin wq[i] = {$urandom, $urandom}; bq[i] = 8'hFF; end
      write_burst(a, n, gap);
      for (int i = 0; i < n; i++) begin wq[i] = {$urandom, $urandom}; bq[i] = 8'($urandom); end
      write_burst(a, n, 0);
      read_burst(a, 8'(n), n);
    end
  endtask

`ifdef DDRAM_RESPONDER_STALL_EN
  task automatic test_stall_burst();
    for (int i = 0; i < 16; i++) begin wq[i] = {$urandom, $urandom}; bq[i] = 8'hFF; end
    write_burst(2000, 16, 0);
    read_burst(2000, 8'd16, 16);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_byte_enables();
    test_burst_wrap();
    test_zero_and_clamp();
    test_rd_we_conflict();
    test_reset_mid_stream();
    test_random();
`ifdef DDRAM_RESPONDER_STALL_EN
    test_stall_burst();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ddram_responder.md
Name: ddram_responder

Overview:
- Avalon-MM burst responder for the DDR3 port. It presents the same signal set the core's DDR initiator drives: rd/we/addr/burstcnt/din/be in, and busy/dout/dout_ready out.
- Backs the port with on-chip block RAM, so the frame-buffer and ROM-fetch paths run in simulation and in small test builds without the HPS DDR3 controller.
- Accepts single and burst reads and writes, applies byte enables, and returns read data after a fixed latency.

Parameters:
- ADDR_WIDTH, 12, number of 64-bit words = 2^ADDR_WIDTH; upper address bits are ignored.
- READ_LATENCY, 4, cycles from read-command acceptance to the first dout_ready beat; legal range 2..15.
- MAX_BURST, 128, largest legal burstcnt; larger values are clamped to MAX_BURST and set error.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rd  in  1  read command request.
- we  in  1  write beat request.
- addr  in  29  64-bit word address; only [ADDR_WIDTH-1:0] is used.
- burstcnt  in  8  burst length, sampled with the first beat of each command.
- din  in  64  write data.
- be  in  8  byte enables; be[i] gates din[8i+7:8i].
- busy  out  1  wait-request; a command or beat is accepted only when busy=0.
- dout  out  64  read data.
- dout_ready  out  1  read data valid, one beat per cycle.
- error  out  1  sticky protocol-violation flag, cleared only by reset.

Behaviour:
- Reset (reset_n=0 at an edge):
  - Outputs: busy=1, dout=0, dout_ready=0, error=0.
  - State → IDLE; all counters cleared; RAM contents preserved.
  - An in-flight burst is abandoned. Remaining read beats are not emitted; remaining write beats are dropped.
- After reset deasserts, busy=0 from the next cycle.
- Accept condition: (rd|we) & ~busy at a rising edge.
- burstcnt rules: burstcnt=0 is treated as 1; burstcnt>MAX_BURST is clamped and sets error.
- States:
  - IDLE:
    - busy=0.
    - we accepted: write din/be to addr; len=burstcnt. If len=1, stay in IDLE; else go to WRITE with beat address addr+1 and remaining len-1.
    - rd accepted: latch addr and len; go to RD_WAIT with counter=READ_LATENCY-1.
    - rd & we in the same cycle: the write wins, the rd is dropped, and error is set.
  - WRITE:
    - busy=0.
    - Each we beat writes to the running address, then address+1 and remaining-1. addr and burstcnt are ignored on these beats.
    - When remaining reaches 0, return to IDLE.
    - Cycles with we=0 are idle gaps; the state is held.
    - rd asserted in WRITE is ignored and sets error.
  - RD_WAIT:
    - busy=1; count down.
    - At 0, go to RD_STREAM so the first beat appears exactly READ_LATENCY cycles after acceptance.
  - RD_STREAM:
    - busy=1; dout_ready=1 with dout=RAM[running address] every cycle, address+1 per beat.
    - After the last beat, go to IDLE. busy=0 in the cycle after the last beat.
    - No gaps; the initiator cannot backpressure read data.
- Address arithmetic: modulo 2^ADDR_WIDTH, so a burst wraps from the top word to word 0.
- RAM: 2^ADDR_WIDTH × 64 with byte write enables, registered read. The pipeline is sized to meet READ_LATENCY exactly.
- A write followed by a read to the same word in the next accepted cycle returns the new data (no stale read).
- dout holds the last beat value when dout_ready=0.

Optional Feature:
- Macro: DDRAM_RESPONDER_STALL_EN.
- Enabled:
  - A 16-bit LFSR (seed 16'hACE1 at reset, taps 16,14,13,11) forces busy=1 in IDLE and WRITE on cycles where lfsr[1:0]=2'b00.
  - Beats and commands offered on those cycles are not accepted and must be held by the initiator.
  - Read-data timing is unchanged once a read is accepted.
- Disabled: no LFSR logic; busy follows the state machine only.

Test Plan:
- Reset then single write: addr=5, din=64'h0123_4567_89AB_CDEF, be=8'hFF, burstcnt=1. Then read addr=5, burstcnt=1 → dout_ready exactly 4 cycles after read acceptance, dout=64'h0123_4567_89AB_CDEF, busy=0 on the following cycle.
- Byte enables: write 64'hFFFF_FFFF_FFFF_FFFF with be=8'hFF to addr=9, then 64'h0 with be=8'h0F → read returns 64'hFFFF_FFFF_0000_0000.
- Burst write of 4 beats (data 1,2,3,4) at addr=4094 with one idle gap after beat 2, then burst read of 4 from 4094 → beats 1,2,3,4 on consecutive cycles, with wrap (4095→0), and busy high from acceptance through the last beat.
- rd and we asserted together in IDLE → write performed, no dout_ready follows, error=1 and remains 1 until reset.
- reset_n low during RD_STREAM of an 8-beat burst after beat 3 → dout_ready=0 and busy=1 at the next edge; no further beats; busy=0 one cycle after release; previously written data still readable.
- With DDRAM_RESPONDER_STALL_EN: a 16-beat write burst with the initiator holding beats while busy=1, then read-back → all 16 words correct, and the observed busy pattern matches the LFSR reference model.
